// File: rtl/ecc_op_sequencer.sv
// ecc_op_sequencer: control FSM that runs one ECC operation (encode, decode
// or full channel) through the datapath for each accepted start pulse.
// Optional statistics counters are built when ECC_SEQ_STATS_EN is defined.
module ecc_op_sequencer #(
  parameter int ENC_LAT = 1,
  parameter int DEC_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [1:0] cw_width,
  output logic       busy,
  output logic       enc_en,
  output logic       dec_en,
  output logic [1:0] mode_q,
  output logic [1:0] width_q,
  output logic       capture,
  output logic       operation_done,
  output logic       cfg_err
`ifdef ECC_SEQ_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ENC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  // Terminal counts: the phase ends on the cycle the counter reaches LAT-1.
  localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(ENC_LAT - 1);
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DEC_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_d, width_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;
  logic             enc_en_q, enc_en_d;
  logic             dec_en_q, dec_en_d;
  logic             done_q, done_d;
  logic             accept;

  // Next-state, latched-config and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    width_d   = width_q;
    cfg_err_d = cfg_err_q;
    accept    = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      ENC: begin
        if (cnt_q == ENC_LAST) begin
          state_d = (mode_q == MODE_FULL) ? DEC : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEC: begin
        if (cnt_q == DEC_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in IDLE or DONE launches a new operation (DONE gives back-to-back).
    if (accept) begin
      cnt_d   = '0;
      width_d = cw_width;
      if (mode == MODE_ILL) begin
        mode_d    = MODE_ENC;
        cfg_err_d = 1'b1;
        state_d   = ENC;
      end else begin
        mode_d  = mode;
        state_d = (mode == MODE_DEC) ? DEC : ENC;
      end
    end

    // Outputs are decoded from the next state so they register with it.
    enc_en_d = (state_d == ENC);
    dec_en_d = (state_d == DEC);
    busy_d   = (state_d == ENC) || (state_d == DEC);
    done_d   = (state_d == DONE);
  end

  // Single state register for the FSM, counter, latched config and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      width_q   <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      enc_en_q  <= 1'b0;
      dec_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      enc_en_q  <= enc_en_d;
      dec_en_q  <= dec_en_d;
      done_q    <= done_d;
    end
  end

  assign busy           = busy_q;
  assign enc_en         = enc_en_q;
  assign dec_en         = dec_en_q;
  assign capture        = done_q;
  assign operation_done = done_q;
  assign cfg_err        = cfg_err_q;

`ifdef ECC_SEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Completed operations wrap; starts dropped while busy saturate.
  always_comb begin
    op_count_d   = op_count_q;
    drop_count_d = drop_count_q;
    if (state_q == DONE) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (start && busy_q && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      op_count_q   <= op_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign op_count   = op_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// tb_ecc_op_sequencer: scoreboard bench for ecc_op_sequencer (ENC_LAT=1, DEC_LAT=2).
module tb_ecc_op_sequencer;

  localparam int ENC_LAT = 1;
  localparam int DEC_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] cw_width = 2'b00;
  logic       busy, enc_en, dec_en, capture, operation_done, cfg_err;
  logic [1:0] mode_q, width_q;
`ifdef ECC_SEQ_STATS_EN
  logic [15:0] op_count, drop_count;
`endif

  ecc_op_sequencer #(.ENC_LAT(ENC_LAT), .DEC_LAT(DEC_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cw_width(cw_width),
    .busy(busy), .enc_en(enc_en), .dec_en(dec_en), .mode_q(mode_q),
    .width_q(width_q), .capture(capture), .operation_done(operation_done),
    .cfg_err(cfg_err)
`ifdef ECC_SEQ_STATS_EN
    , .op_count(op_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    logic [1:0] mode;
    logic [1:0] width;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive a start pulse for one cycle; when accepted, push the expected completion.
  task automatic start_op(input logic [1:0] m, input logic [1:0] w, input bit accepted);
    exp_t e;
    int   lat;
    start    = 1'b1;
    mode     = m;
    cw_width = w;
    if (accepted) begin
      case (m)
        2'b01:   lat = DEC_LAT;
        2'b10:   lat = ENC_LAT + DEC_LAT;
        default: lat = ENC_LAT;
      endcase
      e.done_cyc = cyc + 1 + lat;
      e.mode     = (m == 2'b11) ? 2'b00 : m;
      e.width    = w;
      sb.push_back(e);
      $display("start mode=%0b width=%0b expect done at cycle %0d", m, w, e.done_cyc);
    end else begin
      $display("start mode=%0b width=%0b while busy (expect ignore)", m, w);
    end
    @(negedge clk);
    start    = 1'b0;
    mode     = 2'b11;
    cw_width = 2'b11;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares each completion against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      check("enc_dec_exclusive", {31'd0, enc_en & dec_en}, 0);
      if (operation_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("done_mode_q", {30'd0, mode_q}, {30'd0, e.mode});
          check("done_width_q", {30'd0, width_q}, {30'd0, e.width});
          check("done_capture", {31'd0, capture}, 1);
          check("done_busy", {31'd0, busy}, 0);
          $display("done cycle=%0d mode_q=%0b width_q=%0b", cyc, mode_q, width_q);
        end
      end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
        check("done_late", cyc, sb[0].done_cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, enc_en, dec_en, capture, operation_done, cfg_err, mode_q, width_q}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Encode
    start_op(2'b00, 2'b10, 1);
    check("enc_enc_en", {31'd0, enc_en}, 1);
    check("enc_busy", {31'd0, busy}, 1);
    check("enc_width_q", {30'd0, width_q}, 2);
    check("enc_no_done", {31'd0, operation_done}, 0);
    @(negedge clk);
    check("enc_done_busy_low", {busy, enc_en}, 0);
    wait_drain();

    // Full channel
    start_op(2'b10, 2'b01, 1);
    check("full_enc_en", {enc_en, dec_en}, 2'b10);
    check("full_mode_q", {30'd0, mode_q}, 2);
    @(negedge clk);
    check("full_dec1", {enc_en, dec_en}, 2'b01);
    @(negedge clk);
    check("full_dec2", {enc_en, dec_en}, 2'b01);
    check("full_mode_q2", {30'd0, mode_q}, 2);
    wait_drain();

    // Decode, with a start while busy
    start_op(2'b01, 2'b11, 1);
    start_op(2'b00, 2'b00, 0);
    check("busy_mode_q", {30'd0, mode_q}, 1);
    check("busy_width_q", {30'd0, width_q}, 3);
    check("busy_dec_en", {31'd0, dec_en}, 1);
`ifdef ECC_SEQ_STATS_EN
    check("drop_count", {16'd0, drop_count}, 1);
`endif
    wait_drain();

`ifdef ECC_SEQ_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    // Back-to-back: encode, then decode started in the DONE cycle
    start_op(2'b00, 2'b01, 1);
    @(negedge clk);
    check("b2b_in_done", {31'd0, operation_done}, 1);
    start_op(2'b01, 2'b10, 1);
    check("b2b_dec_en", {31'd0, dec_en}, 1);
    check("b2b_mode_q", {30'd0, mode_q}, 1);
    wait_drain();
`ifdef ECC_SEQ_STATS_EN
    check("op_count", {16'd0, op_count}, 2);
`endif

    // Illegal mode
    start_op(2'b11, 2'b00, 1);
    check("ill_mode_q", {30'd0, mode_q}, 0);
    check("ill_cfg_err", {31'd0, cfg_err}, 1);
    check("ill_enc_en", {31'd0, enc_en}, 1);
    wait_drain();
    start_op(2'b01, 2'b01, 1);
    wait_drain();
    check("cfg_err_sticky", {31'd0, cfg_err}, 1);

    // Reset mid-operation
    start_op(2'b10, 2'b10, 1);
    @(negedge clk);
    check("rst_mid_dec_en", {31'd0, dec_en}, 1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_outputs", {busy, enc_en, dec_en, capture, operation_done, cfg_err, mode_q, width_q}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    start_op(2'b00, 2'b11, 1);
    check("post_rst_enc_en", {31'd0, enc_en}, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
